// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller and decoder_scan_sequencer.
// The master drives the scan request; the slave returns the decoder line drive.
interface decoder_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [15:0]        mask;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         sel;
    logic               sel_en;
    logic               busy;
    logic               pass_done;
    logic               done;

    modport master (
        output start, stop, cont, mask, dwell,
        input  sel, sel_en, busy, pass_done, done
    );

    modport slave (
        input  start, stop, cont, mask, dwell,
        output sel, sel_en, busy, pass_done, done
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Drives a 4-to-16 line decoder through the lines selected by a mask,
// holding each line for a programmable dwell, single-pass or continuous.
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

    state_t             state, state_d;
    logic [3:0]         sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic               busy_q, busy_d;
    logic               pass_done_q, pass_done_d;
    logic               done_q, done_d;
    logic [15:0]        mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] dwell_eff;
    logic [4:0]         nxt;

    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (m[i-1]) idx = 4'(i - 1);
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit strictly above cur
    function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] cur);
        logic [4:0] r;
        r = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (m[i-1] && ((i - 1) > {28'd0, cur})) r = {1'b1, 4'(i - 1)};
        end
        return r;
    endfunction

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign nxt       = next_above(mask_q, sel_q);

    always_comb begin
        state_d     = state;
        sel_d       = sel_q;
        sel_en_d    = sel_en_q;
        busy_d      = busy_q;
        pass_done_d = 1'b0;
        done_d      = 1'b0;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        cnt_d       = cnt_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mask != '0) begin
                        mask_d   = bus.mask;
                        dwell_d  = dwell_eff;
                        cont_d   = bus.cont;
                        cnt_d    = dwell_eff - DWELL_W'(1);
                        sel_d    = lowest_bit(bus.mask);
                        sel_en_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = DRIVE;
                    end else begin
                        done_d  = ~bus.cont;
                        state_d = FINISH;
                    end
                end
            end
            DRIVE: begin
                // stop outranks a line advance that falls in the same cycle
                if (bus.stop) begin
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (nxt[4]) begin
                    sel_d = nxt[3:0];
                    cnt_d = dwell_q - DWELL_W'(1);
                end else if (cont_q) begin
                    sel_d       = lowest_bit(mask_q);
                    cnt_d       = dwell_q - DWELL_W'(1);
                    pass_done_d = 1'b1;
                end else begin
                    sel_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    pass_done_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= '0;
            sel_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            done_q      <= 1'b0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            cont_q      <= 1'b0;
        end else begin
            state       <= state_d;
            sel_q       <= sel_d;
            sel_en_q    <= sel_en_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            done_q      <= done_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            cont_q      <= cont_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_en    = sel_en_q;
    assign bus.busy      = busy_q;
    assign bus.pass_done = pass_done_q;
    assign bus.done      = done_q;
endmodule
